// File: rtl/mult_hilo_unit.sv
// Unsigned 32x32 shift-add multiplier with MIPS-style Hi/Lo result registers.
// One multiply iteration per clock: 32 iterations, then a one-cycle done pulse.
module mult_hilo_unit #(
    parameter logic [5:0] F_MFHI  = 6'h10,
    parameter logic [5:0] F_MTHI  = 6'h11,
    parameter logic [5:0] F_MFLO  = 6'h12,
    parameter logic [5:0] F_MTLO  = 6'h13,
    parameter logic [5:0] F_MULTU = 6'h19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [63:0] product_r;
    logic [31:0] mcand_r;
    logic [4:0]  count_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        accept_mul_s;
    logic        write_hi_s;
    logic        write_lo_s;
    logic        last_iter_s;
    logic [63:0] step_s;

    // One shift-add step; the 33-bit sum keeps the carry so no product bit is lost.
    function automatic logic [63:0] mul_step(input logic [63:0] prod, input logic [31:0] mcand);
        logic [32:0] sum;
        if (prod[0]) begin
            sum = {1'b0, prod[63:32]} + {1'b0, mcand};
        end else begin
            sum = {1'b0, prod[63:32]};
        end
        return {sum, prod[31:1]};
    endfunction

    // Request decode; MTHI/MTLO/MULTU are only honoured while idle.
    always_comb begin
        accept_mul_s = 1'b0;
        write_hi_s   = 1'b0;
        write_lo_s   = 1'b0;
        if (state_r == IDLE && start) begin
            accept_mul_s = (funct == F_MULTU);
            write_hi_s   = (funct == F_MTHI);
            write_lo_s   = (funct == F_MTLO);
        end else begin
            accept_mul_s = 1'b0;
            write_hi_s   = 1'b0;
            write_lo_s   = 1'b0;
        end
    end

    // Iteration datapath and terminal-count detect.
    always_comb begin
        step_s      = mul_step(product_r, mcand_r);
        last_iter_s = (state_r == RUN) && (count_r == 5'd31);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_mul_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == 5'd31) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register with flag outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Multiplier working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            product_r <= 64'd0;
            mcand_r   <= 32'd0;
            count_r   <= 5'd0;
        end else if (accept_mul_s) begin
            product_r <= {32'd0, B};
            mcand_r   <= A;
            count_r   <= 5'd0;
        end else if (state_r == RUN) begin
            product_r <= step_s;
            count_r   <= count_r + 5'd1;
        end else begin
            product_r <= product_r;
            mcand_r   <= mcand_r;
            count_r   <= count_r;
        end
    end

    // Hi/Lo architectural registers; the final step is committed directly so
    // the values are visible in the same cycle done is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (last_iter_s) begin
            hi_r <= step_s[63:32];
            lo_r <= step_s[31:0];
        end else begin
            if (write_hi_s) begin
                hi_r <= A;
            end else begin
                hi_r <= hi_r;
            end
            if (write_lo_s) begin
                lo_r <= A;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    // Read mux is combinational from funct so MFHI/MFLO see Hi/Lo immediately.
    always_comb begin
        result = 32'd0;
        if (funct == F_MFHI) begin
            result = hi_r;
        end else if (funct == F_MFLO) begin
            result = lo_r;
        end else begin
            result = 32'd0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: vector table plus scoreboard queue,
// with hand-written sequences for busy-ignore, done-cycle restart and reset abort.
module tb_mult_hilo_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULTU = 6'h19;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[8];

    mult_hilo_unit #(
        .F_MFHI(F_MFHI), .F_MTHI(F_MTHI), .F_MFLO(F_MFLO),
        .F_MTLO(F_MTLO), .F_MULTU(F_MULTU)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct),
        .A(A), .B(B), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        funct = F_MFHI;
        #1 h = result;
        funct = F_MFLO;
        #1 l = result;
        funct = 6'h00;
    endtask

    task automatic write_reg(input logic [5:0] f, input logic [31:0] d);
        start = 1'b1; funct = f; A = d;
        tick();
        start = 1'b0; funct = 6'h00;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        start = 1'b1; funct = F_MULTU; A = a; B = b;
        sb_q.push_back(exp);
        tick();
        start = 1'b0; funct = 6'h00;
    endtask

    // Called just after the accepting edge; returns at the sample where done is high.
    task automatic wait_done(input string name);
        int lat;
        logic busy_bad;
        logic [63:0] exp;
        logic [31:0] h, l;
        lat = 0;
        busy_bad = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd32);
        check({name, "_busy_in_run"}, {63'd0, busy_bad}, 64'd0);
        check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        read_hilo(h, l);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check({name, "_hi"}, {32'd0, h}, {32'd0, exp[63:32]});
            check({name, "_lo"}, {32'd0, l}, {32'd0, exp[31:0]});
        end
    endtask

    initial begin
        logic [31:0] h, l;
        int pulses;

        vecs[0] = '{32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{32'd0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};
        for (int i = 5; i < 8; i++) begin
            logic [63:0] p;
            vecs[i].a = $urandom;
            vecs[i].b = $urandom;
            p = 64'(vecs[i].a) * 64'(vecs[i].b);
            vecs[i].hi = p[63:32];
            vecs[i].lo = p[31:0];
        end

        rst = 1'b1; start = 1'b0; funct = 6'h00; A = 32'd0; B = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        read_hilo(h, l);
        check("reset_hi", {32'd0, h}, 64'd0);
        check("reset_lo", {32'd0, l}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
            wait_done($sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d_done_one_cycle", i), {63'd0, done}, 64'd0);
        end

        // MTHI/MTLO in idle, then a foreign funct has no effect.
        write_reg(F_MTHI, 32'h1234_5678);
        write_reg(F_MTLO, 32'h9ABC_DEF0);
        read_hilo(h, l);
        check("mthi_idle", {32'd0, h}, 64'h1234_5678);
        check("mtlo_idle", {32'd0, l}, 64'h9ABC_DEF0);
        write_reg(6'h00, 32'hFFFF_FFFF);
        check("other_funct_busy", {63'd0, busy}, 64'd0);
        read_hilo(h, l);
        check("other_funct_hi", {32'd0, h}, 64'h1234_5678);
        check("other_funct_lo", {32'd0, l}, 64'h9ABC_DEF0);

        // MULTU 3*5; a second MULTU at edge 10 and MTHI/MTLO mid-run are ignored.
        issue(32'd3, 32'd5, 64'd15);
        for (int i = 1; i < 10; i++) tick();
        start = 1'b1; funct = F_MULTU; A = 32'd7; B = 32'd9;
        tick();
        start = 1'b1; funct = F_MTHI; A = 32'h1111_1111;
        tick();
        start = 1'b1; funct = F_MTLO; A = 32'h2222_2222;
        tick();
        start = 1'b0; funct = 6'h00;
        read_hilo(h, l);
        check("run_hi_held", {32'd0, h}, 64'h1234_5678);
        check("run_lo_held", {32'd0, l}, 64'h9ABC_DEF0);
        pulses = 0;
        for (int i = 13; i < 60; i++) begin
            if (done === 1'b1) begin
                pulses++;
                if (sb_q.size() != 0) begin
                    logic [63:0] exp;
                    exp = sb_q.pop_front();
                    read_hilo(h, l);
                    check("ignore_hi", {32'd0, h}, {32'd0, exp[63:32]});
                    check("ignore_lo", {32'd0, l}, {32'd0, exp[31:0]});
                end
            end
            tick();
        end
        check("ignore_done_pulses", 64'(pulses), 64'd1);
        check("ignore_sb_drained", 64'(sb_q.size()), 64'd0);

        // MULTU presented during the DONE cycle is not accepted.
        issue(32'd2, 32'd3, 64'd6);
        wait_done("done_cycle");
        start = 1'b1; funct = F_MULTU; A = 32'd4; B = 32'd5;
        tick();
        start = 1'b0; funct = 6'h00;
        check("restart_in_done_busy", {63'd0, busy}, 64'd0);
        check("restart_in_done_done", {63'd0, done}, 64'd0);

        // Reset at edge 16 of a multiply, with start also high, aborts it.
        write_reg(F_MTHI, 32'hAAAA_5555);
        issue(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001);
        for (int i = 1; i < 16; i++) tick();
        rst = 1'b1; start = 1'b1; funct = F_MULTU; A = 32'd7; B = 32'd7;
        tick();
        rst = 1'b0;
        sb_q.delete();
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        read_hilo(h, l);
        check("abort_hi", {32'd0, h}, 64'd0);
        check("abort_lo", {32'd0, l}, 64'd0);
        funct = F_MTHI;
        #1 check("abort_result_other", {32'd0, result}, 64'd0);
        issue(32'd2, 32'd2, 64'd4);
        wait_done("after_abort");
        tick();
        check("after_abort_done_one_cycle", {63'd0, done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_hilo_unit.md
MULT_HILO_UNIT -- requirements
Module: mult_hilo_unit

Interface
REQ-001 SHALL have parameter F_MFHI, default 6'h10, funct code that reads Hi.
REQ-002 SHALL have parameter F_MTHI, default 6'h11, funct code that writes Hi from A.
REQ-003 SHALL have parameter F_MFLO, default 6'h12, funct code that reads Lo.
REQ-004 SHALL have parameter F_MTLO, default 6'h13, funct code that writes Lo from A.
REQ-005 SHALL have parameter F_MULTU, default 6'h19, funct code that starts unsigned multiply.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-008 start  input  1  operation request, qualified by funct.
REQ-009 funct  input  6  operation select.
REQ-010 A  input  32  multiplicand / MTHI-MTLO write data.
REQ-011 B  input  32  multiplier.
REQ-012 busy  output  1  multiply in progress.
REQ-013 done  output  1  one-cycle pulse when multiply result committed to Hi/Lo.
REQ-014 result  output  32  Hi when funct==F_MFHI, Lo when funct==F_MFLO, else 0; combinational from funct and Hi/Lo registers.

Function
REQ-015 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 and funct==F_MULTU at edge k -> capture A (multiplicand), load 64-bit product register {32'd0, B}, iteration counter=0, go to RUN.
REQ-017 RUN: each edge, if product[0]==1 add multiplicand to product[63:32] using 33-bit sum; shift {carry, sum/upper, lower} right by 1; counter+1.
REQ-018 RUN -> DONE at edge k+32 (after exactly 32 iterations); at same edge Hi<=product[63:32], Lo<=product[31:0] of final value.
REQ-019 DONE: done=1 for exactly one cycle (between edges k+32 and k+33), then IDLE unconditionally.
REQ-020 busy=1 in RUN only; busy=0 in IDLE and DONE.
REQ-021 Arithmetic SHALL be unsigned; full 64-bit product, no truncation or overflow.
REQ-022 Hi/Lo SHALL hold previous values throughout RUN; result reads during RUN return old values.
REQ-023 start while RUN or DONE SHALL be ignored (no capture, no restart, no MTHI/MTLO write).
REQ-024 IDLE: start=1 and funct==F_MTHI -> Hi<=A at that edge; funct==F_MTLO -> Lo<=A; no state change.
REQ-025 start=1 with any other funct SHALL have no effect.
REQ-026 Back-to-back: start with F_MULTU in the DONE cycle is ignored; earliest accepted restart is first IDLE cycle (edge k+33).

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, Hi=0, Lo=0, product=0, counter=0, busy=0, done=0; result then 0 for all funct.
REQ-028 rst SHALL take priority over start and over any in-flight multiply; aborted multiply SHALL not write Hi/Lo.
REQ-029 rst and start both high at same edge -> reset wins; start not captured.

Verification
REQ-030 A=3, B=5, MULTU at edge 0 -> busy=1 edges 1..32, done=1 after edge 32 only; MFHI result 0x00000000, MFLO result 0x0000000F.
REQ-031 A=0xFFFFFFFF, B=0xFFFFFFFF, MULTU -> Hi=0xFFFFFFFE, Lo=0x00000001; also A=0x80000000, B=2 -> Hi=0x00000001, Lo=0x00000000.
REQ-032 MULTU 3*5 then second MULTU 7*9 issued at edge 10 (busy) -> ignored; Hi/Lo=0/15 after completion; done pulses once.
REQ-033 MTHI A=0x12345678, MTLO A=0x9ABCDEF0 in IDLE -> MFHI 0x12345678, MFLO 0x9ABCDEF0; same ops during RUN -> no change.
REQ-034 MULTU 0xFFFF*0xFFFF, rst asserted at edge 16 -> next cycle busy=0, done=0, Hi=Lo=0, no done pulse afterward; new MULTU 2*2 accepted next edge gives Lo=4.
REQ-035 Operand 0 (A=0, B=0xDEADBEEF) -> Hi=Lo=0, latency identical to REQ-030.
